// File: rtl/tap_delay_reader.sv
// tap_delay_reader: circular delay line that stores one sample per accepted
// input and then streams every tap, newest to oldest, to a serial consumer.
// Optional feature: define TAP_DELAY_FLUSH_EN to add a synchronous flush
// input that clears the delay line and aborts any stream in progress.
module tap_delay_reader #(
    parameter int N    = 16,
    parameter int TAPS = 8,
    localparam int IW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef TAP_DELAY_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [IW-1:0] out_index,
    output logic          out_last
);

    typedef enum logic {IDLE, STREAM} state_e;

    localparam logic [IW-1:0] LAST_PTR = IW'(TAPS - 1);
    localparam logic [IW-1:0] PENULT   = IW'(TAPS - 2);

    state_e        state_q, state_d;
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [N-1:0]  mem_q [TAPS];
    logic          wr_en;
    logic          flush_w;

`ifdef TAP_DELAY_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Step one tap older; wraps 0 -> TAPS-1 so any TAPS works, not just powers of two.
    function automatic logic [IW-1:0] ptr_dec(input logic [IW-1:0] p);
        return (p == '0) ? LAST_PTR : p - 1'b1;
    endfunction

    // in_ready is held low while reset is asserted, even though state is already IDLE.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign out_last  = last_q;

    // Next-state logic: accept a sample in IDLE, walk the taps in STREAM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        wr_en    = 1'b0;
        if (flush_w) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            idx_d    = '0;
            data_d   = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        rd_ptr_d = wr_ptr_q;
                        idx_d    = '0;
                        data_d   = in_data;   // newest tap bypasses the buffer
                        valid_d  = 1'b1;
                        last_d   = 1'b0;
                        state_d  = STREAM;
                    end
                end
                STREAM: begin
                    if (valid_q && out_ready) begin
                        if (last_q) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            idx_d   = '0;
                            data_d  = '0;
                        end else begin
                            idx_d    = idx_q + 1'b1;
                            rd_ptr_d = ptr_dec(rd_ptr_q);
                            data_d   = mem_q[ptr_dec(rd_ptr_q)];
                            last_d   = (idx_q == PENULT);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Delay-line storage: written once per accepted sample, cleared by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is reset deliberately: never-written taps must read as zero.
            for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
        end else if (flush_w) begin
            for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_tap_delay_reader.sv
// Testbench for tap_delay_reader (N=8, TAPS=4): directed scenarios plus
// randomized pushes and back-pressure, checked against a sample-history model.
module tb_tap_delay_reader;

    localparam int N    = 8;
    localparam int TAPS = 4;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
`ifdef TAP_DELAY_FLUSH_EN
    logic          flush;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: every sample accepted since the last reset/flush, oldest first.
    logic [N-1:0] hist[$];

    always #5 clk = ~clk;

    tap_delay_reader #(.N(N), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef TAP_DELAY_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] exp_tap(input int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    // Offer one sample; expects acceptance within a bounded wait.
    task automatic push(input logic [N-1:0] d);
        int wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        hist.push_back(d);
    endtask

    // Consume a full stream, checking every cycle (including stalled ones,
    // where the expected values simply stay the same).
    task automatic drain(input int stall_at, input int stall_len, input bit rnd, input bit junk);
        int  k      = 0;
        int  stalls = 0;
        int  budget = 0;
        bit  go;
        while (k < TAPS && budget < 200) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_tap(k));
            check("out_index", out_index, k);
            check("out_last", out_last, (k == TAPS - 1));
            check("in_ready_busy", in_ready, 0);
            if (rnd) go = ($urandom_range(0, 3) != 0);
            else     go = !(k == stall_at && stalls < stall_len);
            if (!go) stalls++;
            out_ready = go;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 8'hAA;
            end
            step();
            budget++;
            if (go) k++;
        end
        if (budget >= 200) check("drain_timeout", 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("out_valid_end", out_valid, 0);
        check("in_ready_end", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef TAP_DELAY_FLUSH_EN
        flush     = 1'b0;
`endif
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // Single sample after reset: older taps read zero.
        push(8'h11);
        drain(-1, 0, 1'b0, 1'b0);

        // Five samples, fifth stream crosses the pointer wrap.
        push(8'h22); drain(-1, 0, 1'b0, 1'b0);
        push(8'h33); drain(-1, 0, 1'b0, 1'b0);
        push(8'h44); drain(-1, 0, 1'b0, 1'b0);
        push(8'h55); drain(-1, 0, 1'b0, 1'b0);

        // Back-pressure: hold at index 1 for three cycles.
        push(8'h66);
        drain(1, 3, 1'b0, 1'b0);

        // in_valid during a stream is ignored; next stream must not contain 0xAA.
        push(8'h77);
        drain(-1, 0, 1'b0, 1'b1);
        push(8'h88);
        drain(-1, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream at index 2.
        push(8'h5A);
        step();
        step();
        check("pre_rst_index", out_index, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_index", out_index, 0);
        check("async_rst_in_ready", in_ready, 0);
        hist.delete();
        #2;
        rst_n = 1'b1;
        step();
        check("rst_no_beats", out_valid, 0);
        push(8'h99);
        drain(-1, 0, 1'b0, 1'b0);

`ifdef TAP_DELAY_FLUSH_EN
        // Flush clears the line; flush also aborts a stream in progress.
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
            drain(-1, 0, 1'b0, 1'b0);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        hist.delete();
        check("flush_out_valid", out_valid, 0);
        push(8'h77);
        drain(-1, 0, 1'b0, 1'b0);
        push(8'h12);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        hist.delete();
        check("flush_abort_valid", out_valid, 0);
        check("flush_abort_ready", in_ready, 1);
        push(8'h34);
        drain(-1, 0, 1'b0, 1'b0);
`endif

        // Randomized pushes with random stalls and spurious in_valid.
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom));
            drain(-1, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
